// File: rtl/exec_stage_if.sv
// Execute-stage bus: id-stage operands/control in, mem-stage results and hazard info out.
interface exec_stage_if;
    logic        valid_id;
    logic [31:0] reg_a_id_r;
    logic [31:0] reg_b_id_r;
    logic [31:0] imm_id_r;
    logic [4:0]  reg_wr_addr_id_r;
    logic [3:0]  alu_op_ex;
    logic        alu_src_b_ex;
    logic [31:0] exec_out_ex_r;
    logic [31:0] reg_b_ex_r;
    logic [4:0]  reg_wr_addr_ex_r;
    logic [4:0]  reg_wr_addr_ex;
    logic        stall_ex;

    // Upstream (id stage / control) side
    modport master (
        output valid_id, reg_a_id_r, reg_b_id_r, imm_id_r, reg_wr_addr_id_r,
               alu_op_ex, alu_src_b_ex,
        input  exec_out_ex_r, reg_b_ex_r, reg_wr_addr_ex_r, reg_wr_addr_ex, stall_ex
    );

    // Execute stage side
    modport slave (
        input  valid_id, reg_a_id_r, reg_b_id_r, imm_id_r, reg_wr_addr_id_r,
               alu_op_ex, alu_src_b_ex,
        output exec_out_ex_r, reg_b_ex_r, reg_wr_addr_ex_r, reg_wr_addr_ex, stall_ex
    );
endinterface

// File: rtl/exec_stage.sv
// Execute stage: single-cycle ALU plus an iterative 32-step MUL/DIVU/REMU unit
// that stalls upstream while it runs.
module exec_stage (
    input  logic         clk,
    input  logic         rst,
    exec_stage_if.slave  bus
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned CW   = 5;
    localparam int unsigned AW   = 5;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam logic [1:0] K_MUL  = 2'd0;
    localparam logic [1:0] K_DIVU = 2'd1;
    localparam logic [1:0] K_REMU = 2'd2;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLT  = 4'd5;
    localparam logic [3:0] OP_SLTU = 4'd6;
    localparam logic [3:0] OP_SLL  = 4'd7;
    localparam logic [3:0] OP_SRL  = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;
    localparam logic [3:0] OP_DIVU = 4'd11;
    localparam logic [3:0] OP_REMU = 4'd12;

    logic [0:0]      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      kind_q, kind_d;
    // a: multiplicand / dividend shifting into quotient
    logic [XLEN-1:0] a_q, a_d;
    // b: multiplier / divisor
    logic [XLEN-1:0] b_q, b_d;
    // acc: partial product / partial remainder
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] exec_out_q, exec_out_d;
    logic [XLEN-1:0] reg_b_q, reg_b_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;

    logic [XLEN-1:0] opb_c;
    logic [4:0]      shamt_c;
    logic [XLEN-1:0] alu_res_c;
    logic            is_multi_c;
    logic            stall_c;
    logic [XLEN-1:0] mul_sum_c;
    logic [XLEN:0]   rem_sh_c;
    logic [XLEN-1:0] div_rem_c;
    logic [XLEN-1:0] div_quo_c;

    // Single-cycle ALU
    always_comb begin
        opb_c      = bus.alu_src_b_ex ? bus.imm_id_r : bus.reg_b_id_r;
        shamt_c    = opb_c[4:0];
        is_multi_c = (bus.alu_op_ex == OP_MUL) || (bus.alu_op_ex == OP_DIVU) ||
                     (bus.alu_op_ex == OP_REMU);
        alu_res_c  = '0;
        case (bus.alu_op_ex)
            OP_ADD:  alu_res_c = bus.reg_a_id_r + opb_c;
            OP_SUB:  alu_res_c = bus.reg_a_id_r - opb_c;
            OP_AND:  alu_res_c = bus.reg_a_id_r & opb_c;
            OP_OR:   alu_res_c = bus.reg_a_id_r | opb_c;
            OP_XOR:  alu_res_c = bus.reg_a_id_r ^ opb_c;
            OP_SLT:  alu_res_c = XLEN'($signed(bus.reg_a_id_r) < $signed(opb_c));
            OP_SLTU: alu_res_c = XLEN'(bus.reg_a_id_r < opb_c);
            OP_SLL:  alu_res_c = bus.reg_a_id_r << shamt_c;
            OP_SRL:  alu_res_c = bus.reg_a_id_r >> shamt_c;
            OP_SRA:  alu_res_c = XLEN'($signed(bus.reg_a_id_r) >>> shamt_c);
            default: alu_res_c = '0;
        endcase
    end

    // One shift-add / restoring shift-subtract step on the latched operands
    always_comb begin
        mul_sum_c = acc_q + (b_q[0] ? a_q : '0);
        rem_sh_c  = {acc_q, a_q[XLEN-1]};
        div_quo_c = {a_q[XLEN-2:0], 1'b0};
        div_rem_c = rem_sh_c[XLEN-1:0];
        if (rem_sh_c >= {1'b0, b_q}) begin
            div_rem_c    = XLEN'(rem_sh_c - {1'b0, b_q});
            div_quo_c[0] = 1'b1;
        end
    end

    // Next-state, iteration and output-register logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        kind_d     = kind_q;
        a_d        = a_q;
        b_d        = b_q;
        acc_d      = acc_q;
        exec_out_d = '0;
        reg_b_d    = '0;
        wr_addr_d  = '0;
        stall_c    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.valid_id && is_multi_c) begin
                    stall_c = 1'b1;
                    a_d     = bus.reg_a_id_r;
                    b_d     = opb_c;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_BUSY;
                    case (bus.alu_op_ex)
                        OP_DIVU: kind_d = K_DIVU;
                        OP_REMU: kind_d = K_REMU;
                        default: kind_d = K_MUL;
                    endcase
                end else if (bus.valid_id) begin
                    exec_out_d = alu_res_c;
                    reg_b_d    = bus.reg_b_id_r;
                    wr_addr_d  = bus.reg_wr_addr_id_r;
                end
            end
            default: begin
                stall_c = 1'b1;
                cnt_d   = cnt_q + CW'(1);
                if (kind_q == K_MUL) begin
                    acc_d = mul_sum_c;
                    a_d   = a_q << 1;
                    b_d   = b_q >> 1;
                end else begin
                    acc_d = div_rem_c;
                    a_d   = div_quo_c;
                end
                if (cnt_q == CW'(31)) begin
                    state_d   = ST_IDLE;
                    reg_b_d   = bus.reg_b_id_r;
                    wr_addr_d = bus.reg_wr_addr_id_r;
                    case (kind_q)
                        K_MUL:   exec_out_d = mul_sum_c;
                        K_DIVU:  exec_out_d = div_quo_c;
                        default: exec_out_d = div_rem_c;
                    endcase
                end
            end
        endcase
    end

    // State and pipeline registers, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            kind_q     <= K_MUL;
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            exec_out_q <= '0;
            reg_b_q    <= '0;
            wr_addr_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            kind_q     <= kind_d;
            a_q        <= a_d;
            b_q        <= b_d;
            acc_q      <= acc_d;
            exec_out_q <= exec_out_d;
            reg_b_q    <= reg_b_d;
            wr_addr_q  <= wr_addr_d;
        end
    end

    assign bus.exec_out_ex_r    = exec_out_q;
    assign bus.reg_b_ex_r       = reg_b_q;
    assign bus.reg_wr_addr_ex_r = wr_addr_q;
    assign bus.stall_ex         = stall_c;
    assign bus.reg_wr_addr_ex   = (bus.valid_id && !stall_c) ? bus.reg_wr_addr_id_r : '0;

endmodule

// File: tb/tb_exec_stage.sv
// Directed bench for exec_stage: ALU ops, iterative MUL/DIVU/REMU, reset abort.
module tb_exec_stage;
    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    exec_stage_if bus ();

    exec_stage u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Compare one observed value with its expected value
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic vld, input logic [3:0] op, input logic src,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic [4:0] addr);
        bus.valid_id         = vld;
        bus.alu_op_ex        = op;
        bus.alu_src_b_ex     = src;
        bus.reg_a_id_r       = a;
        bus.reg_b_id_r       = b;
        bus.imm_id_r         = imm;
        bus.reg_wr_addr_id_r = addr;
    endtask

    // Single-cycle op: no stall, result one edge later
    task automatic apply_alu(input string tag, input logic [3:0] op, input logic src,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] imm, input logic [4:0] addr,
                             input logic [31:0] exp);
        drive(1'b1, op, src, a, b, imm, addr);
        #1;
        check({tag, "_stall"}, 32'(bus.stall_ex), 32'd0);
        check({tag, "_wr_c"}, 32'(bus.reg_wr_addr_ex), 32'(addr));
        @(posedge clk); #1;
        check({tag, "_out"}, bus.exec_out_ex_r, exp);
        check({tag, "_regb"}, bus.reg_b_ex_r, b);
        check({tag, "_wr"}, 32'(bus.reg_wr_addr_ex_r), 32'(addr));
    endtask

    // Multi-cycle op: exactly 33 stall cycles of bubbles, then the result
    task automatic run_multi(input string tag, input logic [3:0] op,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] addr, input logic [31:0] exp,
                             input bit scramble, output int stalls);
        int bad;
        bad    = 0;
        stalls = 0;
        drive(1'b1, op, 1'b0, a, b, 32'h0, addr);
        for (int i = 0; i < 33; i++) begin
            #1;
            if (bus.stall_ex) stalls++;
            if (bus.reg_wr_addr_ex != 5'd0) bad++;
            @(posedge clk); #1;
            if (i < 32 && (bus.exec_out_ex_r != 32'd0 || bus.reg_wr_addr_ex_r != 5'd0)) bad++;
            if (scramble && i == 5) begin
                bus.reg_a_id_r = 32'hDEADBEEF;
                bus.alu_op_ex  = 4'd0;
            end
        end
        check({tag, "_stalls"}, 32'(stalls), 32'd33);
        check({tag, "_bubbles"}, 32'(bad), 32'd0);
        check({tag, "_out"}, bus.exec_out_ex_r, exp);
        check({tag, "_regb"}, bus.reg_b_ex_r, b);
        check({tag, "_wr"}, 32'(bus.reg_wr_addr_ex_r), 32'(addr));
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int s1, s2, bad;
        rst = 1'b1;
        drive(1'b0, 4'd0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_out", bus.exec_out_ex_r, 32'h0);
        check("rst_regb", bus.reg_b_ex_r, 32'h0);
        check("rst_wr", 32'(bus.reg_wr_addr_ex_r), 32'd0);
        rst = 1'b0;
        #1;
        check("rst_stall", 32'(bus.stall_ex), 32'd0);
        @(posedge clk); #1;

        apply_alu("add",  4'd0, 1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h0, 5'd5, 32'h80000000);
        apply_alu("sub",  4'd1, 1'b0, 32'h00000005, 32'h00000007, 32'h0, 5'd6, 32'hFFFFFFFE);
        apply_alu("and",  4'd2, 1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h0, 5'd7, 32'h00F000F0);
        apply_alu("or",   4'd3, 1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h0, 5'd8, 32'hFFF0FFF0);
        apply_alu("xor",  4'd4, 1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h0, 5'd9, 32'hFF00FF00);
        apply_alu("slt",  4'd5, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h0, 5'd10, 32'h00000001);
        apply_alu("sltu", 4'd6, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h0, 5'd11, 32'h00000000);
        apply_alu("sll",  4'd7, 1'b1, 32'h00000001, 32'h00000055, 32'h00000021, 5'd12, 32'h00000002);
        apply_alu("srl",  4'd8, 1'b0, 32'h80000000, 32'h0000001F, 32'h0, 5'd13, 32'h00000001);
        apply_alu("sra",  4'd9, 1'b1, 32'h80000000, 32'h00000077, 32'h00000024, 5'd14, 32'hF8000000);
        apply_alu("op13", 4'd13, 1'b0, 32'h12345678, 32'h00000009, 32'h0, 5'd15, 32'h00000000);
        apply_alu("wr0",  4'd0, 1'b0, 32'h00000002, 32'h00000003, 32'h0, 5'd0, 32'h00000005);

        drive(1'b0, 4'd0, 1'b0, 32'h11111111, 32'h22222222, 32'h0, 5'd4);
        #1;
        check("bubble_wr_c", 32'(bus.reg_wr_addr_ex), 32'd0);
        @(posedge clk); #1;
        check("bubble_out", bus.exec_out_ex_r, 32'h0);
        check("bubble_regb", bus.reg_b_ex_r, 32'h0);
        check("bubble_wr", 32'(bus.reg_wr_addr_ex_r), 32'd0);

        run_multi("mul", 4'd10, 32'h00010001, 32'h00010001, 5'd3, 32'h00020001, 1'b1, s1);
        run_multi("mul_ff", 4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'h00000001, 1'b0, s1);
        run_multi("divu", 4'd11, 32'd100, 32'd7, 5'd16, 32'd14, 1'b0, s1);
        run_multi("remu", 4'd12, 32'd100, 32'd7, 5'd17, 32'd2, 1'b0, s2);
        check("b2b_stalls", 32'(s1 + s2), 32'd66);
        run_multi("divu_big", 4'd11, 32'h80000000, 32'd3, 5'd18, 32'h2AAAAAAA, 1'b0, s1);
        run_multi("divu_z", 4'd11, 32'h00001234, 32'd0, 5'd19, 32'hFFFFFFFF, 1'b0, s1);
        run_multi("remu_z", 4'd12, 32'h00001234, 32'd0, 5'd20, 32'h00001234, 1'b0, s1);
        drive(1'b0, 4'd0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
        #1;
        check("stall_drop", 32'(bus.stall_ex), 32'd0);
        @(posedge clk); #1;

        // Reset in BUSY with counter=10 of a MUL
        drive(1'b1, 4'd10, 1'b0, 32'h00010001, 32'h00010001, 32'h0, 5'd3);
        repeat (11) @(posedge clk);
        #1;
        check("pre_rst_stall", 32'(bus.stall_ex), 32'd1);
        rst = 1'b1;
        drive(1'b0, 4'd0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("abort_stall", 32'(bus.stall_ex), 32'd0);
        check("abort_out", bus.exec_out_ex_r, 32'h0);
        check("abort_wr", 32'(bus.reg_wr_addr_ex_r), 32'd0);
        bad = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.exec_out_ex_r != 32'd0 || bus.reg_wr_addr_ex_r != 5'd0 || bus.stall_ex) bad++;
        end
        check("abort_quiet", 32'(bad), 32'd0);

        apply_alu("post_rst_add", 4'd0, 1'b0, 32'd40, 32'd2, 32'h0, 5'd21, 32'd42);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
